// File: rtl/regfile_stream_reader_if.sv
// regfile_stream_reader_if: valid/ready stream of regfile words tagged with source address
interface regfile_stream_reader_if #(
    parameter int DATA_WIDTH = 8,
    parameter int ADDR_WIDTH = 12
);
    logic                  valid;
    logic                  ready;
    logic [DATA_WIDTH-1:0] data;
    logic [ADDR_WIDTH-1:0] addr;
    logic                  last;
    modport master(output valid, data, addr, last, input ready);
    modport slave(input valid, data, addr, last, output ready);
endinterface

// File: rtl/regfile_stream_reader.sv
// regfile_stream_reader: streams a window of an append-only regfile, stalling on unwritten words; REGFILE_READER_TIMEOUT_EN adds a stall timeout
module regfile_stream_reader #(
    parameter int DATA_WIDTH     = 8,
    parameter int ADDR_WIDTH     = 12,
    parameter int TIMEOUT_CYCLES = 1024
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  start,
    input  logic [ADDR_WIDTH-1:0] start_addr,
    input  logic [ADDR_WIDTH:0]   len,
    output logic                  busy,
    output logic                  done,
    output logic                  err,
    input  logic                  wr_we,
    output logic                  ran_re,
    output logic [ADDR_WIDTH-1:0] ran_r_addr,
    input  logic [DATA_WIDTH-1:0] ran_r_data,
    regfile_stream_reader_if.master m
);
    localparam logic [ADDR_WIDTH+1:0] DEPTH = {2'b01, {ADDR_WIDTH{1'b0}}};
    typedef enum logic [1:0] {IDLE, CHECK, RUN, DRAIN} state_t;
    state_t                state, state_nxt;
    logic [ADDR_WIDTH:0]   level, rem;
    logic [ADDR_WIDTH-1:0] cur;
    logic                  avail, accept, overflow, issue, finish, fail, timeout;
    assign avail    = {1'b0, cur} < level;
    assign accept   = m.valid && m.ready;
    assign overflow = {2'b00, cur} + {1'b0, rem} > DEPTH;
`ifdef REGFILE_READER_TIMEOUT_EN
    localparam int TW = $clog2(TIMEOUT_CYCLES + 1);
    logic [TW-1:0] stall_cnt;
    // count consecutive RUN cycles starved of written data; any issued read restarts it
    always_ff @(posedge clk) begin
        if (rst || state != RUN || issue) stall_cnt <= '0;
        else if (!avail) stall_cnt <= stall_cnt + TW'(1);
    end
    assign timeout = state == RUN && !avail && stall_cnt == TW'(TIMEOUT_CYCLES - 1);
`else
    assign timeout = 1'b0;
`endif
    // state register
    always_ff @(posedge clk) begin
        state <= rst ? IDLE : state_nxt;
    end
    // next-state logic
    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    state_nxt = start ? CHECK : IDLE;
            CHECK:   state_nxt = (rem == '0 || overflow) ? IDLE : RUN;
            RUN:     state_nxt = timeout ? IDLE : (issue && rem == (ADDR_WIDTH+1)'(1)) ? DRAIN : RUN;
            DRAIN:   state_nxt = accept ? IDLE : DRAIN;
            default: state_nxt = IDLE;
        endcase
    end
    // read issue and completion decode; the read address is forced to 0 when idle
    always_comb begin
        issue      = state == RUN && avail && (!m.valid || m.ready);
        ran_re     = issue;
        ran_r_addr = issue ? cur : '0;
        finish     = (state == CHECK && rem == '0) || (state == DRAIN && accept);
        fail       = (state == CHECK && rem != '0 && overflow) || timeout;
    end
    // fill-level mirror, window cursor, status pulses and the stream output register
    always_ff @(posedge clk) begin
        if (rst) begin
            level   <= '0;
            cur     <= '0;
            rem     <= '0;
            busy    <= 1'b0;
            done    <= 1'b0;
            err     <= 1'b0;
            m.valid <= 1'b0;
            m.data  <= '0;
            m.addr  <= '0;
            m.last  <= 1'b0;
        end else begin
            level <= (wr_we && !level[ADDR_WIDTH]) ? level + (ADDR_WIDTH+1)'(1) : level;
            done  <= finish;
            err   <= fail;
            busy  <= (state == IDLE) ? start : busy && !finish && !fail;
            if (state == IDLE && start) begin
                cur <= start_addr;
                rem <= len;
            end else if (issue) begin
                cur <= cur + ADDR_WIDTH'(1);
                rem <= rem - (ADDR_WIDTH+1)'(1);
            end
            if (issue) begin
                m.valid <= 1'b1;
                m.data  <= ran_r_data;
                m.addr  <= cur;
                m.last  <= rem == (ADDR_WIDTH+1)'(1);
            end else if (accept || timeout) begin
                m.valid <= 1'b0;
            end
        end
    end
endmodule

// File: tb/tb_regfile_stream_reader.sv
// tb_regfile_stream_reader: directed vectors over a modelled append-only regfile
module tb_regfile_stream_reader;
    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        start = 1'b0;
    logic [11:0] start_addr = '0;
    logic [12:0] len = '0;
    logic        busy, done, err, wr_we = 1'b0, ran_re;
    logic [11:0] ran_r_addr;
    logic [7:0]  ran_r_data, wr_data = '0;
    logic [7:0]  mem [4096];
    int          wptr = 0;
    regfile_stream_reader_if #(.DATA_WIDTH(8), .ADDR_WIDTH(12)) m();
    regfile_stream_reader #(.DATA_WIDTH(8), .ADDR_WIDTH(12), .TIMEOUT_CYCLES(16)) dut (
        .clk(clk), .rst(rst), .start(start), .start_addr(start_addr), .len(len),
        .busy(busy), .done(done), .err(err), .wr_we(wr_we), .ran_re(ran_re),
        .ran_r_addr(ran_r_addr), .ran_r_data(ran_r_data), .m(m)
    );
    always #5 clk = ~clk;
    assign ran_r_data = mem[ran_r_addr];
    always @(posedge clk) begin
        if (rst) wptr <= 0;
        else if (wr_we) begin
            mem[wptr[11:0]] <= wr_data;
            wptr <= wptr + 1;
        end
    end
    typedef struct {logic [7:0] d; int a; int l; int c;} beat_t;
    beat_t beats[$];
    int cyc = 0, n_done = 0, n_err = 0, n_re = 0, bad_reads = 0, done_cyc = 0, err_cyc = 0;
    int tests = 0, fails = 0, start_cyc = 0;
    always @(posedge clk) cyc++;
    always @(negedge clk) begin
        if (m.valid && m.ready) beats.push_back('{m.data, int'(m.addr), int'(m.last), cyc});
        if (done) begin n_done++; done_cyc = cyc; end
        if (err) begin n_err++; err_cyc = cyc; end
        if (ran_re) n_re++;
        if (ran_re && int'(ran_r_addr) >= wptr) bad_reads++;
    end
    task automatic check(input string name, input int act, input int exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask
    task automatic tick();
        @(posedge clk);
        #1;
    endtask
    task automatic write_word(input logic [7:0] d);
        wr_we = 1'b1;
        wr_data = d;
        tick();
        wr_we = 1'b0;
    endtask
    task automatic clear_mon();
        beats.delete();
        n_done = 0; n_err = 0; n_re = 0; bad_reads = 0;
    endtask
    task automatic do_reset();
        rst = 1'b1;
        tick();
        tick();
        rst = 1'b0;
        clear_mon();
    endtask
    task automatic pulse_start(input int sa, input int ln);
        start = 1'b1;
        start_addr = 12'(sa);
        len = 13'(ln);
        start_cyc = cyc;
        tick();
        start = 1'b0;
    endtask
    task automatic wait_end(input string name, input int limit);
        int k;
        for (k = 0; k < limit && n_done + n_err == 0; k++) tick();
        if (n_done + n_err == 0) begin
            fails++;
            tests++;
            $display("FAIL %s: no done/err within %0d cycles", name, limit);
        end
    endtask
    typedef struct {int sa; int ln; logic [7:0] rp; int ed; int ee; int cnt; int fd;} vec_t;
    vec_t vt[7];
    initial begin
        vt[0] = '{2,    4,    8'hFF, 1, 0, 4,  8'h12};
        vt[1] = '{0,    4,    8'hAA, 1, 0, 4,  8'h10};
        vt[2] = '{4090, 7,    8'hFF, 0, 1, 0,  0};
        vt[3] = '{5,    0,    8'hFF, 1, 0, 0,  0};
        vt[4] = '{0,    16,   8'hFF, 1, 0, 16, 8'h10};
        vt[5] = '{15,   1,    8'h36, 1, 0, 1,  8'h1F};
        vt[6] = '{1,    4096, 8'hFF, 0, 1, 0,  0};
        m.ready = 1'b0;
        do_reset();
        check("reset_busy", int'(busy), 0);
        check("reset_done", int'(done), 0);
        check("reset_err", int'(err), 0);
        check("reset_valid", int'(m.valid), 0);
        check("reset_ran_re", int'(ran_re), 0);
        for (int i = 0; i < 16; i++) write_word(8'(8'h10 + i));
        for (int v = 0; v < 7; v++) begin
            clear_mon();
            pulse_start(vt[v].sa, vt[v].ln);
            for (int k = 0; k < 300 && n_done + n_err == 0; k++) begin
                m.ready = vt[v].rp[k % 8];
                tick();
            end
            m.ready = 1'b0;
            check($sformatf("v%0d_done", v), n_done, vt[v].ed);
            check($sformatf("v%0d_err", v), n_err, vt[v].ee);
            check($sformatf("v%0d_beats", v), beats.size(), vt[v].cnt);
            check($sformatf("v%0d_busy_end", v), int'(busy), 0);
            if (vt[v].cnt == 0) check($sformatf("v%0d_no_reads", v), n_re, 0);
            for (int j = 0; j < beats.size(); j++) begin
                check($sformatf("v%0d_data%0d", v, j), int'(beats[j].d), vt[v].fd + j);
                check($sformatf("v%0d_addr%0d", v, j), beats[j].a, vt[v].sa + j);
                check($sformatf("v%0d_last%0d", v, j), beats[j].l, (j == vt[v].cnt - 1) ? 1 : 0);
            end
            if (beats.size() > 0) check($sformatf("v%0d_done_lat", v), done_cyc - beats[beats.size()-1].c, 1);
            tick();
        end
        clear_mon();
        m.ready = 1'b1;
        pulse_start(2, 4);
        check("a_busy", int'(busy), 1);
        start = 1'b1; start_addr = 12'd8; len = 13'd2;
        tick();
        start = 1'b0;
        wait_end("a_end", 50);
        repeat (10) tick();
        check("a_beats", beats.size(), 4);
        check("a_done_once", n_done, 1);
        if (beats.size() == 4) begin
            check("a_first_lat", beats[0].c - start_cyc, 3);
            check("a_rate", beats[3].c - beats[0].c, 3);
            check("a_first_data", int'(beats[0].d), 8'h12);
            check("a_last_data", int'(beats[3].d), 8'h15);
        end
        clear_mon();
        m.ready = 1'b0;
        pulse_start(0, 16);
        repeat (5) tick();
        check("c_valid_held", int'(m.valid), 1);
        check("c_data_held0", int'(m.data), 8'h10);
        repeat (3) tick();
        check("c_data_held1", int'(m.data), 8'h10);
        check("c_addr_held", int'(m.addr), 0);
        rst = 1'b1;
        tick();
        rst = 1'b0;
        check("c_rst_busy", int'(busy), 0);
        check("c_rst_valid", int'(m.valid), 0);
        clear_mon();
        m.ready = 1'b1;
        pulse_start(0, 1);
        repeat (10) tick();
        check("c_level0_beats", beats.size(), 0);
        check("c_level0_reads", n_re, 0);
        check("c_no_done", n_done, 0);
        write_word(8'h55);
        wait_end("c_end", 20);
        check("c_after_write", beats.size() > 0 ? int'(beats[0].d) : -1, 8'h55);
        do_reset();
        m.ready = 1'b1;
        pulse_start(0, 3);
        begin
            int wc[3];
            for (int i = 0; i < 3; i++) begin
                repeat (4) tick();
                wc[i] = cyc;
                write_word(8'(8'hA0 + i));
            end
            wait_end("b_end", 30);
            check("b_beats", beats.size(), 3);
            for (int i = 0; i < beats.size() && i < 3; i++) begin
                check($sformatf("b_data%0d", i), int'(beats[i].d), 8'hA0 + i);
                check($sformatf("b_lat%0d", i), beats[i].c - wc[i], 2);
            end
            check("b_bad_reads", bad_reads, 0);
            check("b_done", n_done, 1);
        end
        do_reset();
        m.ready = 1'b1;
        pulse_start(0, 2);
`ifdef REGFILE_READER_TIMEOUT_EN
        wait_end("t_end", 60);
        check("t_err", n_err, 1);
        check("t_err_lat", err_cyc - start_cyc, 18);
        check("t_busy", int'(busy), 0);
        check("t_valid", int'(m.valid), 0);
`else
        repeat (40) tick();
        check("t_no_err", n_err, 0);
        check("t_still_busy", int'(busy), 1);
        check("t_no_reads", n_re, 0);
`endif
        do_reset();
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
